// File: rtl/lbm_pkg.sv
// lbm_pkg: shared D2Q9 direction tables and sweep FSM state encoding
package lbm_pkg;

   typedef enum logic [3:0] {
      DIR_C0, DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
   } dir_e;

   localparam int NDIR = 9;

   // Screen coordinates: N moves toward y-1, E moves toward x+1
   localparam int DX [NDIR] = '{0,  0,  1, 1, 1, 0, -1, -1, -1};
   localparam int DY [NDIR] = '{0, -1, -1, 0, 1, 1,  1,  0, -1};

   typedef enum logic [1:0] {
      ST_IDLE, ST_SWEEP, ST_DRAIN, ST_DONE
   } state_e;

   // Fold a coordinate that stepped at most one cell past either edge
   function automatic int wrap_coord(input int v, input int n);
      return (v < 0) ? v + n : ((v >= n) ? v - n : v);
   endfunction

endpackage

// File: rtl/lbm_addr_gen.sv
// lbm_addr_gen: neighbour cell index for one streaming direction
// Define LBM_PERIODIC_EN for wrap-around edges; otherwise off-grid neighbours are flagged invalid.
module lbm_addr_gen
   import lbm_pkg::*;
#(
   parameter int GRID_W = 16,
   parameter int GRID_H = 16,
   parameter int XW     = 4,
   parameter int YW     = 4,
   parameter int IW     = 8
) (
   input  logic [XW-1:0] x_i,
   input  logic [YW-1:0] y_i,
   input  dir_e          dir_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int nx;
   int ny;
   int wx;
   int wy;

   assign nx = int'(x_i) + DX[dir_i];
   assign ny = int'(y_i) + DY[dir_i];

`ifdef LBM_PERIODIC_EN
   assign wx      = wrap_coord(nx, GRID_W);
   assign wy      = wrap_coord(ny, GRID_H);
   assign valid_o = 1'b1;
`else
   assign wx      = nx;
   assign wy      = ny;
   assign valid_o = (nx >= 0) && (nx < GRID_W) && (ny >= 0) && (ny < GRID_H);
`endif

   assign idx_o = valid_o ? IW'(wy * GRID_W + wx) : '0;

endmodule

// File: rtl/lbm_sweep_ctrl.sv
// lbm_sweep_ctrl: raster sweep controller for one LBM time step (read, collide, stream-write)
// Define LBM_PERIODIC_EN for periodic lattice edges; default build suppresses off-grid writes.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 9
`endif

module lbm_sweep_ctrl
   import lbm_pkg::*;
#(
   parameter int GRID_W   = 16,
   parameter int GRID_H   = 16,
   parameter int ADDR_W   = `ADDRESS_WIDTH,
   parameter int COLL_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   output logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_en,
   output logic                  cell_valid,
   output logic [9*ADDR_W-1:0]   wr_addr,
   output logic [8:0]            wr_en,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           step_count
);

   localparam int N  = GRID_W * GRID_H;
   localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam int IW = ADDR_W - 1;
   localparam int DL = COLL_LAT + 1;
   localparam int DW = $clog2(COLL_LAT + 1);

   generate
      if (ADDR_W < $clog2(N) + 1 || COLL_LAT < 1) begin : g_bad_cfg
         $error("lbm_sweep_ctrl: ADDR_W too small for grid or COLL_LAT < 1");
      end
   endgenerate

   state_e          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            buf_q, buf_d;
   logic [15:0]     step_q, step_d;
   logic            dv_q [DL];
   logic [XW-1:0]   xs_q [DL];
   logic [YW-1:0]   ys_q [DL];
   logic [IW-1:0]   nidx [9];
   logic [8:0]      nval;
   logic            issue, last_cell, fin;

   assign issue     = (state_q == ST_SWEEP);
   assign last_cell = (x_q == XW'(GRID_W - 1)) && (y_q == YW'(GRID_H - 1));
   assign fin       = (state_q == ST_DRAIN) && (state_d == ST_DONE);

   // State register; en low freezes the FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else if (en) state_q <= state_d;
   end

   // Next state; only takes effect on en cycles, so start is seen as start&en
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  state_d = start ? ST_SWEEP : ST_IDLE;
         ST_SWEEP: state_d = last_cell ? ST_DRAIN : ST_SWEEP;
         ST_DRAIN: state_d = (drain_q == DW'(COLL_LAT)) ? ST_DONE : ST_DRAIN;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs; strobes are masked on frozen cycles and addresses read 0 when idle
   always_comb begin
      busy       = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
      done       = en && (state_q == ST_DONE);
      rd_en      = en && issue;
      rd_addr    = rd_en ? {buf_q, IW'(int'(y_q) * GRID_W + int'(x_q))} : '0;
      cell_valid = en && dv_q[0];
   end

   // Raster counters, drain timer, buffer select and step counter next state
   always_comb begin
      x_d     = (issue && x_q != XW'(GRID_W - 1)) ? x_q + XW'(1) : '0;
      y_d     = !issue ? '0 : (x_q != XW'(GRID_W - 1)) ? y_q : last_cell ? '0 : y_q + YW'(1);
      drain_d = (state_q == ST_DRAIN) ? drain_q + DW'(1) : '0;
      buf_d   = buf_q ^ fin;
      step_d  = step_q + 16'(fin);
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q     <= '0;
         y_q     <= '0;
         drain_q <= '0;
         buf_q   <= 1'b0;
         step_q  <= '0;
      end else if (en) begin
         x_q     <= x_d;
         y_q     <= y_d;
         drain_q <= drain_d;
         buf_q   <= buf_d;
         step_q  <= step_d;
      end
   end

   // Coordinate delay line matching RAM read plus collision latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DL; k++) begin
            dv_q[k] <= 1'b0;
            xs_q[k] <= '0;
            ys_q[k] <= '0;
         end
      end else if (en) begin
         dv_q[0] <= issue;
         xs_q[0] <= x_q;
         ys_q[0] <= y_q;
         for (int k = 1; k < DL; k++) begin
            dv_q[k] <= dv_q[k-1];
            xs_q[k] <= xs_q[k-1];
            ys_q[k] <= ys_q[k-1];
         end
      end
   end

   assign step_count = step_q;

   generate
      for (genvar d = 0; d < 9; d++) begin : g_dir
         lbm_addr_gen #(
            .GRID_W (GRID_W),
            .GRID_H (GRID_H),
            .XW     (XW),
            .YW     (YW),
            .IW     (IW)
         ) u_ag (
            .x_i     (xs_q[DL-1]),
            .y_i     (ys_q[DL-1]),
            .dir_i   (dir_e'(d)),
            .idx_o   (nidx[d]),
            .valid_o (nval[d])
         );
         assign wr_en[d] = en && dv_q[DL-1] && nval[d];
         assign wr_addr[d*ADDR_W +: ADDR_W] = wr_en[d] ? {~buf_q, nidx[d]} : '0;
      end
   endgenerate

endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// tb_lbm_sweep_ctrl: scoreboard bench for lbm_sweep_ctrl on a 4x4 grid, COLL_LAT 2
module tb_lbm_sweep_ctrl;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int L  = 2;
   localparam int AW = 5;
   localparam int N  = W * H;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              start = 1'b0;
   logic [AW-1:0]     rd_addr;
   logic              rd_en, cell_valid, busy, done;
   logic [9*AW-1:0]   wr_addr;
   logic [8:0]        wr_en;
   logic [15:0]       step_count;

   always #5 clk = ~clk;

   lbm_sweep_ctrl #(.GRID_W(W), .GRID_H(H), .ADDR_W(AW), .COLL_LAT(L)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .start      (start),
      .rd_addr    (rd_addr),
      .rd_en      (rd_en),
      .cell_valid (cell_valid),
      .wr_addr    (wr_addr),
      .wr_en      (wr_en),
      .busy       (busy),
      .done       (done),
      .step_count (step_count)
   );

   typedef struct packed {
      logic [8:0]      we;
      logic [9*AW-1:0] wa;
   } wrec_t;

   logic [AW-1:0] rd_q [$];
   wrec_t         wr_q [$];
   int            cv_due [$];
   int            wr_due [$];

   int checks = 0, failures = 0;
   int done_cnt = 0, rd_seen = 0;
   int cyc = 0, en_cnt = 0, t_first = 0, lows = 0, exp_steps = 0;
   bit quiet = 0, tmo = 0, fin_chk = 0, model_buf = 0, ok;
   int dxt [9] = '{0,  0,  1, 1, 1, 0, -1, -1, -1};
   int dyt [9] = '{0, -1, -1, 0, 1, 1,  1,  0, -1};
   wrec_t         rec;
   logic [9*AW-1:0] mask;

   // Expected streaming writes for one cell, straight from the neighbour rules
   function automatic wrec_t exp_wr(input int x, input int y, input bit b);
      wrec_t r = '0;
      for (int d = 0; d < 9; d++) begin
         int nx = x + dxt[d];
         int ny = y + dyt[d];
`ifdef LBM_PERIODIC_EN
         nx = (nx + W) % W;
         ny = (ny + H) % H;
`endif
         if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
            r.we[d] = 1'b1;
            r.wa[d*AW +: AW] = {~b, 4'(ny * W + nx)};
         end
      end
      return r;
   endfunction

   task automatic push_step();
      for (int i = 0; i < N; i++) begin
         rd_q.push_back({model_buf, 4'(i)});
         wr_q.push_back(exp_wr(i % W, i / W, model_buf));
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a strobe
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         cv_due.delete();
         wr_due.delete();
         exp_steps = 0;
         rd_seen = 0;
      end
      if (!rst || quiet) begin
         chk("idle_outputs", {rd_addr, rd_en, cell_valid, wr_addr, wr_en, busy, done}, 64'd0);
         chk("idle_step_count", step_count, 64'(exp_steps));
      end
      if (rst) begin
         if (en) en_cnt++;
         else begin
            chk("strobes_en_low", {rd_en, cell_valid, wr_en}, 64'd0);
            if (rd_seen > 0) lows++;
         end
         if (rd_en) begin
            chk("rd_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) chk("rd_addr", rd_addr, rd_q.pop_front());
            if (rd_seen == 0) begin
               t_first = cyc;
               lows = 0;
            end
            rd_seen++;
            cv_due.push_back(en_cnt);
            wr_due.push_back(en_cnt);
         end
         if (cell_valid) begin
            chk("cv_expected", cv_due.size() != 0, 1);
            if (cv_due.size() != 0) chk("cell_valid_lat", en_cnt - cv_due.pop_front(), 1);
         end
         if (wr_en != 0) begin
            chk("wr_expected", wr_q.size() != 0 && wr_due.size() != 0, 1);
            if (wr_q.size() != 0 && wr_due.size() != 0) begin
               rec = wr_q.pop_front();
               for (int d = 0; d < 9; d++) mask[d*AW +: AW] = {AW{rec.we[d]}};
               chk("wr_lat", en_cnt - wr_due.pop_front(), L + 1);
               chk("wr_en", wr_en, rec.we);
               chk("wr_addr", wr_addr & mask, rec.wa);
            end
         end
         if (en && rd_seen > 0) chk("busy", busy, !done);
         if (done) begin
            chk("done_expected", rd_seen != 0, 1);
            chk("step_cycles", cyc - t_first, N + L + 1 + lows);
            chk("cells_issued", rd_seen, N);
            chk("step_count", step_count, 64'(16'(exp_steps + 1)));
            exp_steps++;
            done_cnt++;
            rd_seen = 0;
         end
      end
      if (tmo) chk("done_timeout", done_cnt, 64'(done_cnt + 1));
      if (fin_chk) chk("queues_drained", rd_q.size() + wr_q.size() + cv_due.size() + wr_due.size(), 0);
   end

   // mode 0: en held high; 1: five-cycle en gap mid-sweep; 2: random en plus stray starts
   task automatic run_step(input int mode, output bit good);
      int d0 = done_cnt;
      push_step();
      start = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk);
         #1;
         if (done_cnt != d0) break;
         start = (mode == 2) && (c == 4 || c == 12);
         en = start ? 1'b1 : (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 6 && c < 11) : ($urandom_range(0, 3) != 0);
      end
      good = (done_cnt != d0);
      start = 1'b0;
      en = 1'b1;
      model_buf = ~model_buf;
      @(posedge clk);
      #1;
   endtask

   task automatic finish_run();
      fin_chk = 1'b1;
      @(negedge clk);
      #1;
      fin_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic abort_run();
      tmo = 1'b1;
      @(negedge clk);
      #1;
      tmo = 1'b0;
      finish_run();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      en = 1'b1;
      quiet = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b1;
      en = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      quiet = 1'b0;
      run_step(0, ok);
      if (!ok) abort_run();
      run_step(1, ok);
      if (!ok) abort_run();
      for (int s = 0; s < 4; s++) begin
         run_step(2, ok);
         if (!ok) abort_run();
      end
      push_step();
      start = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (rd_seen >= 7) break;
      end
      rst = 1'b0;
      rd_q.delete();
      wr_q.delete();
      model_buf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      quiet = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      quiet = 1'b0;
      run_step(0, ok);
      if (!ok) abort_run();
      run_step(2, ok);
      if (!ok) abort_run();
      finish_run();
   end

endmodule
